// File: rtl/rv32i_mem_pkg.sv
// rv32i_mem_pkg: shared memory-size default, length width and loader state type
package rv32i_mem_pkg;
    localparam int MEM_BYTES_DEF = 256;
    localparam int LEN_W = 16;
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, LOAD, CHK} loader_state_t;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: length-prefixed byte stream into the instruction-memory write port; IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte
module imem_loader
    import rv32i_mem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold
);
    loader_state_t state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d, hdr_len;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic we_q, we_d, done_q, done_d, error_q, error_d, acc;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
`endif

    assign in_ready  = state_q != IDLE;
    assign acc       = in_valid && in_ready;
    assign hdr_len   = {len_q[15:8], in_data};
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign done      = done_q;
    assign error     = error_q;
    // the core stays held until the final registered write has left the port
    assign busy      = (state_q != IDLE) || we_q;
    assign cpu_hold  = busy;

    // next-state: header decode, range check, payload write staging and status flags
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        error_d = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                done_d  = 1'b0;
                error_d = 1'b0;
                state_d = LEN_HI;
            end
            LEN_HI: if (acc) begin
                len_d   = {in_data, 8'h00};
                state_d = LEN_LO;
            end
            LEN_LO: if (acc) begin
                len_d = hdr_len;
                idx_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_d = '0;
`endif
                if (hdr_len == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (BASE_ADDR + int'(hdr_len) > MEM_BYTES) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = LOAD;
                end
            end
            LOAD: if (acc) begin
                we_d    = 1'b1;
                addr_d  = ADDR_W'(BASE_ADDR + int'(idx_q));
                wdata_d = in_data;
                idx_d   = idx_q + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_d   = sum_q + in_data;
`endif
                if (idx_q == len_q - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = CHK;
`else
                    done_d  = 1'b1;
                    state_d = IDLE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: if (acc) begin
                done_d  = (sum_q + in_data) == 8'h00;
                error_d = (sum_q + in_data) != 8'h00;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // state and output registers; reset drops any staged write
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            error_q <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end
endmodule
